pll_lock_monitor: RTL and testbench

Synthesizable lock detector and lock-time meter for the digital PLL. It consumes the 26-bit trim word driven by the PLL controller, clocked by the reference oscillator. It reports lock, lock time in reference cycles, and acquisition timeout. The block is the in-silicon counterpart to the trim-driving controller and feeds the housekeeping/status registers.

---
 rtl/pll_lock_monitor_pkg.sv | 16 +
 rtl/pll_lock_monitor_popcount.sv | 20 ++
 rtl/pll_lock_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_monitor_pkg.sv
// pll_mon_pkg: shared FSM state encoding and sizing helper for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  // Number of bits needed to hold a population count of a w-bit vector.
  function automatic int popcount_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pll_lock_monitor_popcount.sv
// pll_popcount: purely combinational count of set bits in a W-bit vector.
module pll_popcount
  import pll_mon_pkg::*;
#(
  parameter int W  = 26,
  parameter int CW = popcount_width(W)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count
);

  // Sum the individual bits of vec.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: lock detector and lock-time meter for the digital PLL trim word.
// Optional macro PLL_LOCK_MONITOR_IRQ_EN adds a sticky irq output with an irq_clr input.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int TRIM_W     = 26,
  parameter int DIV_W      = 5,
  parameter int LOCK_COUNT = 5,
  parameter int MAX_WAIT   = 50,
  parameter int CNT_W      = 8,
  parameter int UNLOCK_TOL = 1
) (
  input  logic              osc,
  input  logic              resetb,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic [TRIM_W-1:0] trim,
`ifdef PLL_LOCK_MONITOR_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic              locked,
  output logic              lock_valid,
  output logic [CNT_W-1:0]  lock_cycles,
  output logic              timeout,
  output logic [1:0]        state
);

  localparam int               PC_W       = popcount_width(TRIM_W);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W:0]   WAIT_LIMIT = (CNT_W+1)'(MAX_WAIT);

  mon_state_e        state_q, state_d;
  logic [TRIM_W-1:0] prev_trim_q, prev_trim_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  lock_cycles_q, lock_cycles_d;
  logic              locked_q, locked_d;
  logic              lock_valid_q, lock_valid_d;
  logic              timeout_q, timeout_d;

  logic [PC_W-1:0]   dev_cnt;
  logic              trim_match, lock_hit, dev_over, div_chg;
  logic [CNT_W:0]    wait_inc;
  logic [CNT_W-1:0]  wait_sat, stable_inc;

  pll_popcount #(
    .W  (TRIM_W),
    .CW (PC_W)
  ) u_popcount (
    .vec   (trim ^ prev_trim_q),
    .count (dev_cnt)
  );

  assign trim_match = (trim == prev_trim_q);
  assign lock_hit   = trim_match && (stable_cnt_q == LOCK_LAST);
  // wait_inc is one bit wider so wait_cnt+1 can be compared against MAX_WAIT without wrap.
  assign wait_inc   = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign wait_sat   = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_inc[CNT_W-1:0];
  assign stable_inc = (stable_cnt_q == {CNT_W{1'b1}}) ? stable_cnt_q : stable_cnt_q + CNT_W'(1);
  assign dev_over   = (int'(dev_cnt) > UNLOCK_TOL);
  // A divider change only matters once acquisition has started; IDLE reloads div_q anyway.
  assign div_chg    = (state_q != IDLE) && (div != div_q);

  // Next-state and next-output logic, ordered enable > div change > FSM transition.
  always_comb begin
    state_d       = state_q;
    prev_trim_d   = prev_trim_q;
    div_d         = div_q;
    stable_cnt_d  = stable_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    lock_cycles_d = lock_cycles_q;
    locked_d      = locked_q;
    lock_valid_d  = 1'b0;
    timeout_d     = timeout_q;
    if (!enable) begin
      state_d      = IDLE;
      locked_d     = 1'b0;
      timeout_d    = 1'b0;
      stable_cnt_d = '0;
      wait_cnt_d   = '0;
    end else if (div_chg) begin
      state_d      = ACQUIRE;
      div_d        = div;
      prev_trim_d  = trim;
      stable_cnt_d = '0;
      wait_cnt_d   = '0;
      locked_d     = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = ACQUIRE;
          prev_trim_d  = trim;
          div_d        = div;
          stable_cnt_d = '0;
          wait_cnt_d   = '0;
        end
        ACQUIRE: begin
          wait_cnt_d  = wait_sat;
          prev_trim_d = trim;
          if (trim_match) begin
            stable_cnt_d = stable_inc;
          end else begin
            stable_cnt_d = '0;
          end
          // Lock is checked first so it wins when it coincides with the timeout edge.
          if (lock_hit) begin
            state_d       = LOCKED;
            locked_d      = 1'b1;
            lock_valid_d  = 1'b1;
            lock_cycles_d = wait_inc[CNT_W-1:0];
          end else if (wait_inc == WAIT_LIMIT) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
          end
        end
        LOCKED: begin
          prev_trim_d = trim;
          if (dev_over) begin
            state_d      = ACQUIRE;
            locked_d     = 1'b0;
            stable_cnt_d = '0;
            wait_cnt_d   = '0;
          end else begin
            state_d = LOCKED;
          end
        end
        TIMEOUT: begin
          state_d = TIMEOUT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge osc) begin
    if (!resetb) begin
      state_q       <= IDLE;
      prev_trim_q   <= '0;
      div_q         <= '0;
      stable_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      lock_cycles_q <= '0;
      locked_q      <= 1'b0;
      lock_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_trim_q   <= prev_trim_d;
      div_q         <= div_d;
      stable_cnt_q  <= stable_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      lock_cycles_q <= lock_cycles_d;
      locked_q      <= locked_d;
      lock_valid_q  <= lock_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign locked      = locked_q;
  assign lock_valid  = lock_valid_q;
  assign lock_cycles = lock_cycles_q;
  assign timeout     = timeout_q;
  assign state       = state_q;

`ifdef PLL_LOCK_MONITOR_IRQ_EN
  logic irq_q, irq_d, irq_set;

  // Set events: losing lock through excess trim deviation, or entering TIMEOUT.
  assign irq_set = (state_q == ACQUIRE && state_d == TIMEOUT) ||
                   (state_q == LOCKED && enable && !div_chg && dev_over);

  // Sticky interrupt; a set event beats a simultaneous clear.
  always_comb begin
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt register with synchronous active-low reset.
  always_ff @(posedge osc) begin
    if (!resetb) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: directed and randomized checks of pll_lock_monitor against a behavioural model.
module tb_pll_lock_monitor;

  localparam int TRIM_W     = 26;
  localparam int DIV_W      = 5;
  localparam int LOCK_COUNT = 5;
  localparam int MAX_WAIT   = 50;
  localparam int CNT_W      = 8;
  localparam int UNLOCK_TOL = 1;

  logic              osc = 1'b0;
  logic              resetb;
  logic              enable;
  logic              irq_clr;
  logic [DIV_W-1:0]  div;
  logic [TRIM_W-1:0] trim;
  logic              locked, lock_valid, timeout;
  logic [CNT_W-1:0]  lock_cycles;
  logic [1:0]        state;
`ifdef PLL_LOCK_MONITOR_IRQ_EN
  logic              irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: state as 0=idle 1=acquire 2=locked 3=timeout; counts as plain integers.
  int                m_state = 0;
  int                m_run   = 0;   // consecutive matching acquire edges
  int                m_edges = 0;   // acquire edges since acquisition (re)started
  int                m_lc    = 0;
  bit                m_locked = 1'b0, m_lv = 1'b0, m_to = 1'b0, m_irq = 1'b0;
  logic [TRIM_W-1:0] m_prev = '0;
  logic [DIV_W-1:0]  m_div  = '0;

  logic [12:0] obs_v, exp_v;
  assign obs_v = {state, locked, lock_valid, timeout, lock_cycles};
  assign exp_v = {2'(m_state), m_locked, m_lv, m_to, 8'(m_lc)};

  pll_lock_monitor #(
    .TRIM_W(TRIM_W), .DIV_W(DIV_W), .LOCK_COUNT(LOCK_COUNT),
    .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .UNLOCK_TOL(UNLOCK_TOL)
  ) dut (
    .osc(osc),
    .resetb(resetb),
    .enable(enable),
    .div(div),
    .trim(trim),
`ifdef PLL_LOCK_MONITOR_IRQ_EN
    .irq_clr(irq_clr),
    .irq(irq),
`endif
    .locked(locked),
    .lock_valid(lock_valid),
    .lock_cycles(lock_cycles),
    .timeout(timeout),
    .state(state)
  );

  always #5 osc = ~osc;

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_edge();
    bit set_irq;
    set_irq = 1'b0;
    if (!resetb) begin
      m_state = 0; m_run = 0; m_edges = 0; m_lc = 0;
      m_locked = 0; m_lv = 0; m_to = 0; m_irq = 0;
      m_prev = '0; m_div = '0;
    end else begin
      m_lv = 0;
      if (!enable) begin
        m_state = 0; m_locked = 0; m_to = 0;
      end else if (m_state != 0 && div != m_div) begin
        m_state = 1; m_div = div; m_prev = trim;
        m_run = 0; m_edges = 0; m_locked = 0; m_to = 0;
      end else begin
        case (m_state)
          0: begin
            m_state = 1; m_prev = trim; m_div = div; m_run = 0; m_edges = 0;
          end
          1: begin
            m_edges = m_edges + 1;
            m_run   = (trim == m_prev) ? m_run + 1 : 0;
            m_prev  = trim;
            if (m_run == LOCK_COUNT) begin
              m_state = 2; m_locked = 1; m_lv = 1; m_lc = m_edges;
            end else if (m_edges == MAX_WAIT) begin
              m_state = 3; m_to = 1; set_irq = 1;
            end
          end
          2: begin
            if ($countones(trim ^ m_prev) > UNLOCK_TOL) begin
              m_state = 1; m_locked = 0; m_run = 0; m_edges = 0; set_irq = 1;
            end
            m_prev = trim;
          end
          default: ;
        endcase
      end
      if (set_irq) m_irq = 1;
      else if (irq_clr) m_irq = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge osc);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b1; irq_clr = 1'b0; div = 5'd17; trim = 26'($urandom);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (obs_v !== 13'h0) begin n_err++; $display("FAIL reset_outputs got %h want %h", obs_v, 13'h0); end
    end
    resetb = 1'b1; enable = 1'b0;
    tick();
    n_vec++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_idle got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_const_lock();
    trim = 26'h0001FFF; div = 5'd17; enable = 1'b1;
    tick();
    n_vec++;
    if (state !== 2'd1) begin n_err++; $display("FAIL const_enter_acq got %0d want 1", state); end
    for (int k = 1; k <= LOCK_COUNT; k++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL const_model k=%0d got %h want %h", k, obs_v, exp_v); end
      n_vec++;
      if (locked !== 1'(k == 5)) begin n_err++; $display("FAIL const_locked k=%0d got %b", k, locked); end
      n_vec++;
      if (lock_valid !== 1'(k == 5)) begin n_err++; $display("FAIL const_lock_valid k=%0d got %b", k, lock_valid); end
    end
    n_vec++;
    if (lock_cycles !== 8'd5) begin n_err++; $display("FAIL const_lock_cycles got %0d want 5", lock_cycles); end
    tick();
    n_vec++;
    if ({locked, lock_valid} !== 2'b10) begin n_err++; $display("FAIL const_pulse_end got %b want 10", {locked, lock_valid}); end
  endtask

  task automatic test_changing_trim();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    for (int k = 1; k <= 17; k++) begin
      if (k <= 12) trim = trim ^ (26'($urandom) | 26'h1);
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL chg_model k=%0d got %h want %h", k, obs_v, exp_v); end
      n_vec++;
      if ({locked, timeout} !== {1'(k == 17), 1'b0}) begin
        n_err++; $display("FAIL chg_lock_to k=%0d got %b%b", k, locked, timeout);
      end
    end
    n_vec++;
    if (lock_cycles !== 8'd17) begin n_err++; $display("FAIL chg_lock_cycles got %0d want 17", lock_cycles); end
  endtask

  task automatic test_timeout();
    enable = 1'b0; tick();
    enable = 1'b1; div = 5'd17; tick();
    for (int k = 1; k <= MAX_WAIT + 3; k++) begin
      trim = trim ^ 26'h1;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL to_model k=%0d got %h want %h", k, obs_v, exp_v); end
      n_vec++;
      if ({locked, timeout} !== {1'b0, 1'(k >= 50)}) begin
        n_err++; $display("FAIL to_flag k=%0d got %b%b", k, locked, timeout);
      end
    end
    div = 5'd18;
    tick();
    n_vec++;
    if ({state, timeout} !== 3'b010) begin n_err++; $display("FAIL to_div_restart got %b want 010", {state, timeout}); end
    for (int k = 1; k <= LOCK_COUNT; k++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL to_relock k=%0d got %h want %h", k, obs_v, exp_v); end
    end
    n_vec++;
    if ({locked, lock_cycles} !== {1'b1, 8'd5}) begin
      n_err++; $display("FAIL to_relock_cycles got %b/%0d want 1/5", locked, lock_cycles);
    end
  endtask

  task automatic test_unlock();
    logic [TRIM_W-1:0] flips [4];
    bit                keep  [4];
    flips[0] = 26'h0000100; keep[0] = 1'b1;
    flips[1] = 26'h0002000; keep[1] = 1'b1;
    flips[2] = 26'h0003000; keep[2] = 1'b0;
    flips[3] = 26'h0000007; keep[3] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      trim = trim ^ flips[f];
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL unl_model f=%0d got %h want %h", f, obs_v, exp_v); end
      n_vec++;
      if (locked !== keep[f]) begin n_err++; $display("FAIL unl_locked f=%0d got %b want %b", f, locked, keep[f]); end
      if (!keep[f]) begin
        for (int k = 1; k <= LOCK_COUNT; k++) begin
          tick();
          n_vec++;
          if (locked !== 1'(k == 5)) begin n_err++; $display("FAIL unl_relock f=%0d k=%0d got %b", f, k, locked); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; tick();
    enable = 1'b1; tick(); tick(); tick();
    resetb = 1'b0;
    tick();
    n_vec++;
    if (obs_v !== 13'h0) begin n_err++; $display("FAIL mid_reset got %h want 0", obs_v); end
    resetb = 1'b1;
    tick();
    for (int k = 1; k <= LOCK_COUNT; k++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL mid_relock k=%0d got %h want %h", k, obs_v, exp_v); end
    end
    n_vec++;
    if ({locked, lock_cycles} !== {1'b1, 8'd5}) begin
      n_err++; $display("FAIL mid_lock_cycles got %b/%0d want 1/5", locked, lock_cycles);
    end
  endtask

`ifdef PLL_LOCK_MONITOR_IRQ_EN
  task automatic test_irq();
    resetb = 1'b0; irq_clr = 1'b0; tick();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_reset got %b want 0", irq); end
    resetb = 1'b1; enable = 1'b1;
    for (int k = 0; k <= LOCK_COUNT; k++) tick();
    trim = trim ^ 26'h0000700;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_sticky k=%0d got %b want 1", k, irq); end
    end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b want 0", irq); end
    div = div + 5'd1; tick();
    for (int k = 1; k <= MAX_WAIT; k++) begin
      trim = trim ^ 26'h1;
      irq_clr = 1'(k == MAX_WAIT);
      tick();
      n_vec++;
      if ({irq, timeout} !== {m_irq, m_to}) begin n_err++; $display("FAIL irq_model k=%0d got %b%b want %b%b", k, irq, timeout, m_irq, m_to); end
    end
    irq_clr = 1'b0;
    n_vec++;
    if ({irq, timeout} !== 2'b11) begin n_err++; $display("FAIL irq_set_wins got %b%b want 11", irq, timeout); end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      resetb  = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 49) != 0);
      irq_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) div = 5'($urandom);
      r = $urandom_range(0, 99);
      if (r < 55) trim = trim;
      else if (r < 75) trim = trim ^ (26'd1 << $urandom_range(0, 25));
      else if (r < 85) trim = trim ^ (26'd1 << $urandom_range(0, 25)) ^ (26'd1 << $urandom_range(0, 25));
      else trim = 26'($urandom);
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL rand_model i=%0d got %h want %h", i, obs_v, exp_v); end
`ifdef PLL_LOCK_MONITOR_IRQ_EN
      n_vec++;
      if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq i=%0d got %b want %b", i, irq, m_irq); end
`endif
    end
    irq_clr = 1'b0;
  endtask

  initial begin
    resetb = 1'b0; enable = 1'b0; irq_clr = 1'b0; div = '0; trim = '0;
    test_reset();
    test_const_lock();
    test_changing_trim();
    test_timeout();
    test_unlock();
    test_reset_mid();
`ifdef PLL_LOCK_MONITOR_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
